// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared pipelined memory read port between I- and D-cache block fills.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed D priority.
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     d_req,
    input  logic [ADDR_W-1:0]        d_addr,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_data_valid,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     i_grant,
    output logic                     d_grant,
    output logic                     i_data_valid,
    output logic                     d_data_valid,
    output logic [DATA_W-1:0]        fill_data,
    output logic [$clog2(WORDS)-1:0] fill_idx,
    output logic                     i_fill_done,
    output logic                     d_fill_done
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q;
    logic              owner_q;   // 1 = D-cache owns the port
    logic              i_grant_q, d_grant_q;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  iss_cnt_q;
    logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic              accept, d_wins;

    // Returned words count only while a fill is in flight and the block is not yet full.
    assign accept    = mem_data_valid && (state_q == ISSUE || state_q == WAIT)
                       && (rcv_cnt_q != CNT_W'(WORDS));
    assign rcv_cnt_d = rcv_cnt_q + CNT_W'(accept);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_owner_q;   // 1 = D was granted last
    assign d_wins = d_req && (!i_req || !last_owner_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_owner_q <= 1'b0;
        else if (state_q == IDLE && (i_req || d_req))
            last_owner_q <= d_wins;
    end
`else
    assign d_wins = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            base_q    <= '0;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_req || d_req) begin
                    owner_q   <= d_wins;
                    base_q    <= (d_wins ? d_addr : i_addr) & ~ADDR_W'(2*WORDS-1);
                    i_grant_q <= !d_wins;
                    d_grant_q <= d_wins;
                    iss_cnt_q <= '0;
                    rcv_cnt_q <= '0;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    iss_cnt_q <= iss_cnt_q + IDX_W'(1);
                    rcv_cnt_q <= rcv_cnt_d;
                    if (iss_cnt_q == IDX_W'(WORDS-1))
                        state_q <= WAIT;
                end
                WAIT: begin
                    rcv_cnt_q <= rcv_cnt_d;
                    if (rcv_cnt_d == CNT_W'(WORDS))
                        state_q <= DONE;
                end
                DONE: begin
                    i_grant_q <= 1'b0;
                    d_grant_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd       = (state_q == ISSUE);
    assign mem_addr     = mem_rd ? (base_q | (ADDR_W'(iss_cnt_q) << 1)) : '0;
    assign i_grant      = i_grant_q;
    assign d_grant      = d_grant_q;
    assign i_data_valid = accept && !owner_q;
    assign d_data_valid = accept && owner_q;
    assign fill_data    = mem_data;
    assign fill_idx     = rcv_cnt_q[IDX_W-1:0];
    assign i_fill_done  = (state_q == DONE) && !owner_q;
    assign d_fill_done  = (state_q == DONE) && owner_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: latency-4 memory model plus address/data scoreboards.
module tb_cache_mem_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_req = 0, d_req = 0;
    logic [15:0] i_addr = '0, d_addr = '0;
    logic        mem_rd, mem_data_valid;
    logic [15:0] mem_addr, mem_data, fill_data;
    logic        i_grant, d_grant, i_data_valid, d_data_valid, i_fill_done, d_fill_done;
    logic [2:0]  fill_idx;

    cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .i_grant(i_grant), .d_grant(d_grant), .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .fill_data(fill_data), .fill_idx(fill_idx), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done));

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: fixed latency 4, can be muted so words are injected by hand.
    logic             mem_off = 0, inj_v = 0;
    logic [15:0]      inj_d = '0;
    logic [3:0]       pv;
    logic [3:0][15:0] pa;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pa <= '0;
        end else begin
            pv <= {pv[2:0], mem_rd & ~mem_off};
            pa <= {pa[2:0], mem_addr};
        end
    end
    assign mem_data_valid = pv[3] | inj_v;
    assign mem_data       = inj_v ? inj_d : (pv[3] ? memfn(pa[3]) : 16'h0);

    typedef struct packed {logic own; logic [2:0] idx; logic [15:0] data;} exp_t;
    logic [15:0] addr_q[$];
    exp_t        data_q[$];
    int          n_valid = 0;

    task automatic expect_fill(input logic own, input logic [15:0] a);
        logic [15:0] base;
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            addr_q.push_back(base + 16'(2*k));
            data_q.push_back('{own: own, idx: 3'(k), data: memfn(base + 16'(2*k))});
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        logic [15:0] ea;
        chk("one_grant", i_grant & d_grant, 0);
        if (mem_rd) begin
            chk("addr_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) begin
                ea = addr_q.pop_front();
                chk("mem_addr", mem_addr, ea);
            end
        end
        if (i_data_valid | d_data_valid) begin
            n_valid++;
            chk("data_expected", data_q.size() != 0, 1);
            if (data_q.size() != 0) begin
                e = data_q.pop_front();
                chk("dv_owner", {i_data_valid, d_data_valid}, e.own ? 2'b01 : 2'b10);
                chk("fill_idx", fill_idx, e.idx);
                chk("fill_data", fill_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits for a fill_done pulse; exp_cyc counts negedges from the current cycle (-1: don't care).
    task automatic wait_done(input string tag, input logic own, input int exp_cyc);
        int cyc = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (i_fill_done | d_fill_done) begin cyc = k; break; end
        end
        chk({tag, "_done_seen"}, cyc >= 0, 1);
        if (cyc >= 0) begin
            chk({tag, "_done_owner"}, {i_fill_done, d_fill_done}, own ? 2'b01 : 2'b10);
            if (exp_cyc >= 0) chk({tag, "_done_cycle"}, cyc, exp_cyc);
        end
        tick();
        chk({tag, "_idle_after_done"}, {i_grant, d_grant, i_fill_done, d_fill_done, mem_rd}, 0);
        chk({tag, "_queues_drained"}, addr_q.size() + data_q.size(), 0);
    endtask

    function automatic logic [40:0] outs();
        return {mem_rd, mem_addr, i_grant, d_grant, i_data_valid, d_data_valid,
                i_fill_done, d_fill_done, fill_idx, fill_data};
    endfunction

    initial begin
        tick(); tick();
        chk("reset_outputs", outs(), 0);
        rst_n = 1;
        tick();

        // Single D miss at 1234
        expect_fill(1'b1, 16'h1234);
        d_addr = 16'h1234; d_req = 1;
        tick();
        chk("t1_grant", {i_grant, d_grant, mem_rd, mem_addr}, {2'b01, 1'b1, 16'h1230});
        d_req = 0;
        wait_done("t1", 1'b1, 12);
        chk("t1_valid_count", n_valid, 8);

        // I request raised mid D-fill is deferred until DONE
        expect_fill(1'b1, 16'h4448);
        d_addr = 16'h4448; d_req = 1;
        tick();
        d_req = 0;
        tick(); tick(); tick();
        i_addr = 16'h5678; i_req = 1;
        tick();
        chk("t3_no_i_grant", i_grant, 0);
        wait_done("t3d", 1'b1, 8);
        expect_fill(1'b0, 16'h5678);
        tick();
        chk("t3_i_grant", {i_grant, d_grant, mem_addr}, {2'b10, 16'h5670});
        i_req = 0;
        wait_done("t3i", 1'b0, 12);

        // Spurious valid in IDLE, early fill finished during ISSUE, 9th valid in WAIT
        mem_off = 1;
        inj_v = 1; inj_d = 16'hBEEF;
        @(negedge clk);
        chk("t4_idle_spurious", {i_data_valid, d_data_valid}, 0);
        tick();
        inj_v = 0;
        for (int k = 0; k < 8; k++) begin
            addr_q.push_back(16'h2000 + 16'(2*k));
            data_q.push_back('{own: 1'b1, idx: 3'(k), data: 16'hC000 + 16'(k)});
        end
        d_addr = 16'h2003; d_req = 1;
        tick();
        d_req = 0;
        for (int k = 0; k < 8; k++) begin
            inj_v = 1; inj_d = 16'hC000 + 16'(k);
            tick();
        end
        chk("t4_wait_no_rd", mem_rd, 0);
        inj_d = 16'hBAD0;
        @(negedge clk);
        chk("t4_ninth_ignored", {d_data_valid, d_fill_done}, 0);
        tick();
        inj_v = 0;
        chk("t4_done", {d_fill_done, d_grant}, 2'b11);
        tick();
        chk("t4_after", {d_fill_done, d_grant, addr_q.size() + data_q.size()}, 0);
        mem_off = 0;

        // Tie at reset release
        rst_n = 0;
        i_addr = 16'h0100; d_addr = 16'h0200; i_req = 1; d_req = 1;
        tick();
        rst_n = 1;
        expect_fill(1'b1, 16'h0200);
        tick();
        chk("t2_first_d", {i_grant, d_grant}, 2'b01);
        wait_done("t2a", 1'b1, 12);
        d_addr = 16'h0300;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        expect_fill(1'b0, 16'h0100);
        tick();
        chk("t2_rr_i", {i_grant, d_grant}, 2'b10);
        i_req = 0;
        wait_done("t2b", 1'b0, 12);
        expect_fill(1'b1, 16'h0300);
        tick();
        chk("t2_rr_d", {i_grant, d_grant}, 2'b01);
        d_req = 0;
        wait_done("t2c", 1'b1, 12);
`else
        expect_fill(1'b1, 16'h0300);
        tick();
        chk("t2_fixed_d", {i_grant, d_grant}, 2'b01);
        d_req = 0;
        wait_done("t2b", 1'b1, 12);
        expect_fill(1'b0, 16'h0100);
        tick();
        chk("t2_fixed_i", {i_grant, d_grant}, 2'b10);
        i_req = 0;
        wait_done("t2c", 1'b0, 12);
`endif

        // Reset after the 3rd returned word, then a fresh I fill
        n_valid = 0;
        expect_fill(1'b0, 16'h3000);
        i_addr = 16'h3000; i_req = 1;
        tick();
        i_req = 0;
        for (int k = 0; k < 40 && n_valid < 3; k++) @(negedge clk);
        chk("t5_three_words", n_valid, 3);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("t5_reset_outputs", outs(), 0);
        addr_q.delete();
        data_q.delete();
        tick(); tick();
        rst_n = 1;
        expect_fill(1'b0, 16'h00A7);
        i_addr = 16'h00A7; i_req = 1;
        tick();
        chk("t5_restart", {i_grant, mem_rd, mem_addr, fill_idx}, {1'b1, 1'b1, 16'h00A0, 3'd0});
        i_req = 0;
        wait_done("t5", 1'b0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
